// File: rtl/mano_pkg.sv
// Shared constants, opcode names and decode helper for the basic-computer
// timing/decode slice.
package mano_pkg;

    localparam int SC_WIDTH   = 3;
    localparam int IR_WIDTH   = 16;
    localparam int I_BIT      = IR_WIDTH - 1;
    localparam int OPCODE_MSB = IR_WIDTH - 2;
    localparam int OPCODE_LSB = IR_WIDTH - 4;

    // Memory-reference opcodes; 7 selects the register/IO instruction group.
    localparam logic [2:0] AND    = 3'd0;
    localparam logic [2:0] ADD    = 3'd1;
    localparam logic [2:0] LDA    = 3'd2;
    localparam logic [2:0] STA    = 3'd3;
    localparam logic [2:0] BUN    = 3'd4;
    localparam logic [2:0] BSA    = 3'd5;
    localparam logic [2:0] ISZ    = 3'd6;
    localparam logic [2:0] IO_REG = 3'd7;

    // 3-to-8 opcode decoder: exactly one output bit per opcode.
    function automatic logic [7:0] opcode_onehot(input logic [2:0] op);
        logic [7:0] oh;
        case (op)
            AND:     oh = 8'h01;
            ADD:     oh = 8'h02;
            LDA:     oh = 8'h04;
            STA:     oh = 8'h08;
            BUN:     oh = 8'h10;
            BSA:     oh = 8'h20;
            ISZ:     oh = 8'h40;
            IO_REG:  oh = 8'h80;
            default: oh = 8'h01;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mano_timing_decoder_if.sv
// Control-side bundle between the bus/control equations and the timing decoder.
interface mano_timing_decoder_if #(
    parameter int SC_WIDTH = 3,
    parameter int IR_WIDTH = 16
);
    logic [IR_WIDTH-1:0]      bus_in;
    logic                     ir_ld;
    logic                     sc_clr;
    logic                     start;
    logic                     halt;
    logic [2**SC_WIDTH-1:0]   T;
    logic [7:0]               D;
    logic                     I;
    logic [IR_WIDTH-1:0]      ir_q;
    logic                     running;

    // Control logic side: drives strobes, consumes timing and decode.
    modport master (
        output bus_in, ir_ld, sc_clr, start, halt,
        input  T, D, I, ir_q, running
    );

    // Timing decoder side.
    modport slave (
        input  bus_in, ir_ld, sc_clr, start, halt,
        output T, D, I, ir_q, running
    );
endinterface

// File: rtl/mano_seq_counter.sv
// Sequence counter with registered one-hot timing vector and run/halt flop S.
// T is rotated in lockstep with SC rather than decoded from it, so the timing
// lines never glitch.
module mano_seq_counter #(
    parameter int SC_WIDTH     = 3,
    parameter bit RUN_ON_RESET = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sc_clr_i,
    input  logic                   start_i,
    input  logic                   halt_i,
    output logic [2**SC_WIDTH-1:0] t_o,
    output logic                   running_o
);
    localparam int T_WIDTH = 2**SC_WIDTH;
    localparam logic [T_WIDTH-1:0]  T0_ONEHOT = {{(T_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SC_WIDTH-1:0] SC_ONE    = {{(SC_WIDTH-1){1'b0}}, 1'b1};

    logic [SC_WIDTH-1:0] sc_q, sc_d;
    logic [T_WIDTH-1:0]  t_q, t_d;
    logic                s_q, s_d;
    logic                adv_s;

    // Next-state for SC/T (clear beats advance) and for S (halt beats start).
    always_comb begin
        sc_d  = sc_q;
        t_d   = t_q;
        s_d   = s_q;
        // A halt sampled at this edge already blocks the advance.
        adv_s = s_q & ~halt_i;
        if (sc_clr_i) begin
            sc_d = {SC_WIDTH{1'b0}};
            t_d  = T0_ONEHOT;
        end else if (adv_s) begin
            sc_d = sc_q + SC_ONE;
            t_d  = {t_q[T_WIDTH-2:0], t_q[T_WIDTH-1]};
        end else begin
            sc_d = sc_q;
            t_d  = t_q;
        end
        if (halt_i) begin
            s_d = 1'b0;
        end else if (start_i) begin
            s_d = 1'b1;
        end else begin
            s_d = s_q;
        end
    end

    // State registers; reset parks the counter at T0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_q <= {SC_WIDTH{1'b0}};
            t_q  <= T0_ONEHOT;
            s_q  <= RUN_ON_RESET;
        end else begin
            sc_q <= sc_d;
            t_q  <= t_d;
            s_q  <= s_d;
        end
    end

    assign t_o       = t_q;
    assign running_o = s_q;

endmodule

// File: rtl/mano_timing_decoder.sv
// Timing and opcode decode for the basic computer: instruction register,
// opcode decoder, indirect bit and the sequence counter.
module mano_timing_decoder #(
    parameter int SC_WIDTH     = mano_pkg::SC_WIDTH,
    parameter int IR_WIDTH     = mano_pkg::IR_WIDTH,
    parameter bit RUN_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mano_timing_decoder_if.slave  bus
);
    import mano_pkg::*;

    localparam int OP_MSB = IR_WIDTH - 2;
    localparam int OP_LSB = IR_WIDTH - 4;

    logic [IR_WIDTH-1:0]    ir_q, ir_d;
    logic [2**SC_WIDTH-1:0] t_s;
    logic                   running_s;

    // IR captures the bus whenever ir_ld is high, regardless of S or sc_clr.
    always_comb begin
        ir_d = ir_q;
        if (bus.ir_ld) begin
            ir_d = bus.bus_in;
        end else begin
            ir_d = ir_q;
        end
    end

    // Instruction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= {IR_WIDTH{1'b0}};
        end else begin
            ir_q <= ir_d;
        end
    end

    mano_seq_counter #(
        .SC_WIDTH     (SC_WIDTH),
        .RUN_ON_RESET (RUN_ON_RESET)
    ) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .sc_clr_i  (bus.sc_clr),
        .start_i   (bus.start),
        .halt_i    (bus.halt),
        .t_o       (t_s),
        .running_o (running_s)
    );

    assign bus.T       = t_s;
    assign bus.running = running_s;
    assign bus.ir_q    = ir_q;
    assign bus.I       = ir_q[IR_WIDTH-1];
    // D follows IR directly so control equations see the new opcode right
    // after the load edge.
    assign bus.D       = opcode_onehot(ir_q[OP_MSB:OP_LSB]);

endmodule

// File: doc/mano_timing_decoder.md
Name: mano_timing_decoder

Overview:
- Produces the timing vector T[7:0] and the opcode decode D[7:0] that the control-logic blocks (PC, AR, AC control) combine into register LD/INC/CLR strobes.
- Contains the sequence counter (SC) with its run/halt flip-flop (S), the instruction register (IR), and the 3-to-8 opcode decoder. It also provides the indirect bit I.
- Sits between the common bus and every control-equation block of the basic computer.

Parameters:
- SC_WIDTH, 3, sequence counter width; T width is 2**SC_WIDTH (8 at default).
- IR_WIDTH, 16, instruction register width; IR[IR_WIDTH-1] is I, IR[IR_WIDTH-2:IR_WIDTH-4] is the opcode.
- RUN_ON_RESET, 1, value S takes on reset (1 = counter runs immediately after reset release).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bus_in  input  IR_WIDTH  common bus, source for IR load.
- ir_ld  input  1  load IR from bus_in at this edge (control asserts during T1).
- sc_clr  input  1  clear SC to 0 at this edge (end of instruction / interrupt entry).
- start  input  1  set S (resume counting).
- halt  input  1  clear S (HLT instruction).
- T  output  2**SC_WIDTH  one-hot timing vector, registered.
- D  output  8  one-hot opcode decode of IR opcode field.
- I  output  1  indirect bit, IR MSB.
- ir_q  output  IR_WIDTH  current IR contents.
- running  output  1  current value of S.

Behaviour:
- The interface is clocked by clk. rst_n is asynchronous and active-low; reset asserts immediately and releases synchronously to clk.
- Reset values:
  - SC = 0, so T = 8'h01 (T0).
  - IR = 0, so D = 8'h01 (D0) and I = 0.
  - S = RUN_ON_RESET.
- SC update per edge, in priority order:
  1. sc_clr = 1: SC goes to 0, regardless of S.
  2. Else if S = 1: SC increments, wrapping from 2**SC_WIDTH-1 to 0 (T7 goes to T0).
  3. Else: SC holds.
- T is held as a registered one-hot vector updated in lockstep with SC. T is never decoded combinationally from SC, so it is glitch-free.
- Exactly one T bit is high at all times, including during and after reset.
- IR loads bus_in when ir_ld = 1, independent of S and sc_clr. The new IR is visible at ir_q, D and I in the cycle after the load edge (1-cycle latency).
- D = 1 << IR opcode field. D is combinational from the IR register, so exactly one bit is high.
- S update:
  - halt = 1 clears S.
  - Else start = 1 sets S.
  - halt and start asserted together: halt wins.
  - Halt takes effect at the edge it is sampled. SC does not increment at that edge unless sc_clr is also asserted.
- While halted, T is frozen on its current bit. IR loads and sc_clr are still honoured.
- ir_ld and sc_clr in the same cycle: both take effect.
- rst_n asserted mid-instruction returns all state to reset values immediately, with no completion of the current step.

Decomposition:
- Shared package mano_pkg holds:
  - Constants: SC_WIDTH, IR_WIDTH, OPCODE_MSB/LSB, I_BIT.
  - Opcode localparams: AND=0, ADD=1, LDA=2, STA=3, BUN=4, BSA=5, ISZ=6, IO_REG=7.
- One natural sub-module: mano_seq_counter. It covers SC, the one-hot T register and the S flip-flop. The IR and decoder stay in the top module.

Test Plan:
- Reset, release with RUN_ON_RESET=1, no other inputs -> T sequence 01,02,04,…,80,01 on consecutive edges (wrap verified).
- At T3 pulse sc_clr -> next cycle T=8'h01. Repeat with sc_clr at T7 -> T=8'h01, not double-advanced.
- Drive bus_in=16'hC123 with ir_ld at T1 -> next cycle ir_q=16'hC123, I=1, D=8'h10 (opcode 4, BUN).
- Assert halt at T2 -> T stays 8'h04 for 5 cycles and running=0. Then assert start -> T=8'h08 on the following edge.
- Assert halt+start together at T5 -> S=0, T held at 8'h20. Then assert halt with sc_clr together -> T=8'h01 while still halted.
- Drop rst_n asynchronously mid-cycle at T6 with IR=16'h7FFF -> T=8'h01, D=8'h01, I=0, ir_q=0 before the next clock edge.
